// File: rtl/fan_pwm_pkg.sv
// Shared types and helpers for the multi-channel fan PWM driver.
package fan_pwm_pkg;

    // Per-channel operating state.
    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_KICK = 2'd1,
        CH_RUN  = 2'd2
    } ch_state_t;

    // Extended duty arithmetic width: one bit of headroom over a 16-bit duty,
    // so channels up to WIDTH=16 can step without wrapping.
    localparam int DUTY_EXT_W = 17;
    typedef logic [DUTY_EXT_W-1:0] duty_ext_t;

    // Move duty toward target by at most step; a zero step jumps straight there.
    function automatic duty_ext_t ramp_next(input duty_ext_t duty,
                                            input duty_ext_t target,
                                            input duty_ext_t step);
        duty_ext_t result;
        if (step == {DUTY_EXT_W{1'b0}}) begin
            result = target;
        end else if (target > duty) begin
            if ((target - duty) > step) begin
                result = duty + step;
            end else begin
                result = target;
            end
        end else begin
            if ((duty - target) > step) begin
                result = duty - step;
            end else begin
                result = target;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fan_pwm_multi_channel.sv
// One fan channel: OFF/KICK/RUN state machine, ramped duty and registered PWM.
module fan_pwm_channel
    import fan_pwm_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int RAMP_STEP    = 4,
    parameter int KICK_PERIODS = 2
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt,
    input  logic             boundary,
    input  logic [WIDTH-1:0] target,
    output logic             pwm,
    output logic             at_target
);

    localparam int KW = (KICK_PERIODS < 2) ? 1 : $clog2(KICK_PERIODS + 1);
    localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIODS);

    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_nxt;
    logic [KW-1:0]    kick_cnt;
    logic [KW-1:0]    kick_nxt;
    logic [KW-1:0]    kick_inc;
    logic             pwm_nxt;
    logic             at_nxt;
    logic             target_zero;

    // Next state, duty and kick count; everything moves only at a period boundary.
    always_comb begin
        state_nxt   = state;
        duty_nxt    = duty;
        kick_nxt    = kick_cnt;
        kick_inc    = kick_cnt + KW'(1);
        target_zero = (target == {WIDTH{1'b0}});
        if (!enable) begin
            state_nxt = CH_OFF;
            duty_nxt  = {WIDTH{1'b0}};
            kick_nxt  = {KW{1'b0}};
        end else if (boundary) begin
            case (state)
                CH_OFF: begin
                    if (target_zero) begin
                        state_nxt = CH_OFF;
                    end else if (KICK_PERIODS == 0) begin
                        state_nxt = CH_RUN;
                        duty_nxt  = target;
                    end else begin
                        state_nxt = CH_KICK;
                        kick_nxt  = {KW{1'b0}};
                    end
                end
                CH_KICK: begin
                    if (target_zero) begin
                        state_nxt = CH_OFF;
                        duty_nxt  = {WIDTH{1'b0}};
                        kick_nxt  = {KW{1'b0}};
                    end else if (kick_inc == KICK_LAST) begin
                        state_nxt = CH_RUN;
                        duty_nxt  = target;
                        kick_nxt  = {KW{1'b0}};
                    end else begin
                        kick_nxt  = kick_inc;
                    end
                end
                CH_RUN: begin
                    if (target_zero && (duty == {WIDTH{1'b0}})) begin
                        state_nxt = CH_OFF;
                    end else begin
                        duty_nxt = WIDTH'(ramp_next(duty_ext_t'(duty),
                                                    duty_ext_t'(target),
                                                    duty_ext_t'(RAMP_STEP)));
                    end
                end
                default: begin
                    state_nxt = CH_OFF;
                    duty_nxt  = {WIDTH{1'b0}};
                    kick_nxt  = {KW{1'b0}};
                end
            endcase
        end else begin
            state_nxt = state;
        end
    end

    // PWM level and at-target flag from the current state, registered below.
    always_comb begin
        case (state)
            CH_KICK: pwm_nxt = 1'b1;
            CH_RUN:  pwm_nxt = (cnt < duty);
            default: pwm_nxt = 1'b0;
        endcase
        at_nxt = ((state == CH_RUN) && (duty == target)) ||
                 ((state == CH_OFF) && (target == {WIDTH{1'b0}}));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= CH_OFF;
            duty      <= {WIDTH{1'b0}};
            kick_cnt  <= {KW{1'b0}};
            pwm       <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= state_nxt;
            duty      <= duty_nxt;
            kick_cnt  <= kick_nxt;
            pwm       <= enable ? pwm_nxt : 1'b0;
            at_target <= at_nxt;
        end
    end

endmodule

// File: rtl/fan_pwm_multi.sv
// Multi-channel fan PWM: shared prescaler/period counter feeding CHANNELS channels.
module fan_pwm_multi
    import fan_pwm_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int PRESCALE     = 1,
    parameter int RAMP_STEP    = 4,
    parameter int KICK_PERIODS = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] speed,
    output logic [CHANNELS-1:0]       pwm_data,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       at_target
);

    localparam int PW = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    // Last count value of a period: MAX-1 = 2^WIDTH-2.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] cnt;
    logic             tick;
    logic             boundary;

    // Counter tick and period-wrap detection.
    always_comb begin
        tick     = (prescaler == PRE_LAST);
        boundary = enable && tick && (cnt == CNT_LAST);
    end

    // Prescaler, period counter and period_start pulse; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (arst) begin
            prescaler    <= {PW{1'b0}};
            cnt          <= {WIDTH{1'b0}};
            period_start <= 1'b0;
        end else if (!enable) begin
            prescaler    <= {PW{1'b0}};
            cnt          <= {WIDTH{1'b0}};
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (tick) begin
                prescaler <= {PW{1'b0}};
                cnt       <= (cnt == CNT_LAST) ? {WIDTH{1'b0}} : cnt + WIDTH'(1);
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        fan_pwm_channel #(
            .WIDTH        (WIDTH),
            .RAMP_STEP    (RAMP_STEP),
            .KICK_PERIODS (KICK_PERIODS)
        ) u_ch (
            .clk       (clk),
            .arst      (arst),
            .enable    (enable),
            .cnt       (cnt),
            .boundary  (boundary),
            .target    (speed[i*WIDTH +: WIDTH]),
            .pwm       (pwm_data[i]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_fan_pwm_multi.sv
// Bench for fan_pwm_multi: per-cycle period-level model plus directed literal checks.
module tb_fan_pwm_multi;

    localparam int CH   = 4;
    localparam int W    = 8;
    localparam int RS   = 4;
    localparam int KP   = 2;
    localparam int PLEN = 255;   // cycles per period at PRESCALE=1

    localparam int S_OFF  = 0;
    localparam int S_KICK = 1;
    localparam int S_RUN  = 2;

    logic            clk = 1'b0;
    logic            arst;
    logic            enable;
    logic [CH*W-1:0] speed;
    logic [CH-1:0]   pwm_data;
    logic            period_start;
    logic [CH-1:0]   at_target;

    fan_pwm_multi #(
        .CHANNELS(CH), .WIDTH(W), .PRESCALE(1), .RAMP_STEP(RS), .KICK_PERIODS(KP)
    ) dut (
        .clk(clk), .arst(arst), .enable(enable), .speed(speed),
        .pwm_data(pwm_data), .period_start(period_start), .at_target(at_target)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            pos;          // cycles elapsed in the current period
    int            mst   [CH];
    int            mduty [CH];
    int            mkick [CH];
    logic [CH-1:0] epwm;
    logic [CH-1:0] eat;
    logic          eps;
    bit            armed = 1'b0;

    function automatic int tgt_of(input int c);
        return int'(speed[c*W +: W]);
    endfunction

    function automatic logic at_of(input int c);
        return ((mst[c] == S_RUN) && (mduty[c] == tgt_of(c))) ||
               ((mst[c] == S_OFF) && (tgt_of(c) == 0));
    endfunction

    task automatic period_rules(input int c);
        int t;
        t = tgt_of(c);
        if (mst[c] == S_OFF) begin
            if (t != 0) begin
                if (KP == 0) begin mst[c] = S_RUN; mduty[c] = t; end
                else begin mst[c] = S_KICK; mkick[c] = 0; end
            end
        end else if (mst[c] == S_KICK) begin
            if (t == 0) begin
                mst[c] = S_OFF; mduty[c] = 0;
            end else begin
                mkick[c] = mkick[c] + 1;
                if (mkick[c] >= KP) begin mst[c] = S_RUN; mduty[c] = t; end
            end
        end else begin
            if (mduty[c] == 0 && t == 0) mst[c] = S_OFF;
            else if (RS == 0) mduty[c] = t;
            else if (t > mduty[c]) mduty[c] = (t - mduty[c] > RS) ? mduty[c] + RS : t;
            else mduty[c] = (mduty[c] - t > RS) ? mduty[c] - RS : t;
        end
    endtask

    task automatic model_edge();
        bit bnd;
        if (arst) begin
            pos = 0; epwm = '0; eat = '0; eps = 1'b0; armed = 1'b1;
            for (int c = 0; c < CH; c++) begin mst[c] = S_OFF; mduty[c] = 0; mkick[c] = 0; end
        end else if (!enable) begin
            pos = 0; eps = 1'b0; epwm = '0;
            for (int c = 0; c < CH; c++) begin
                eat[c] = at_of(c); mst[c] = S_OFF; mduty[c] = 0; mkick[c] = 0;
            end
        end else begin
            bnd = (pos == PLEN - 1);
            for (int c = 0; c < CH; c++) begin
                epwm[c] = (mst[c] == S_KICK) ? 1'b1 :
                          (mst[c] == S_RUN)  ? (pos < mduty[c]) : 1'b0;
                eat[c]  = at_of(c);
                if (bnd) period_rules(c);
            end
            eps = bnd;
            pos = bnd ? 0 : pos + 1;
        end
    endtask

    // Compare process: model advances at each edge, outputs compared 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_edge();
            #1;
            if (armed) begin
                check("pwm_data", pwm_data, epwm);
                check("period_start", period_start, eps);
                check("at_target", at_target, eat);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int hcnt [CH];

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        repeat (n) tick1();
    endtask

    task automatic set_speed(input int c, input int v);
        @(negedge clk);
        speed[c*W +: W] = 8'(v);
    endtask

    // Step to the next period_start sample, counting cycles and high levels.
    task automatic wait_ps(input string name, output int k);
        k = 0;
        for (int c = 0; c < CH; c++) hcnt[c] = 0;
        do begin
            tick1();
            k++;
            for (int c = 0; c < CH; c++) if (pwm_data[c]) hcnt[c]++;
        end while (!period_start && k < 2000);
        if (!period_start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no period_start within %0d cycles", name, k);
        end
    endtask

    // Count high cycles per channel over one full period from a period_start sample.
    task automatic measure();
        for (int c = 0; c < CH; c++) hcnt[c] = 0;
        for (int k = 0; k < PLEN; k++) begin
            tick1();
            for (int c = 0; c < CH; c++) if (pwm_data[c]) hcnt[c]++;
        end
    endtask

    initial begin
        int k;
        int sum;
        int nps;
        arst   = 1'b1;
        enable = 1'b1;
        speed  = {CH{8'h80}};

        // 1. reset and first kick
        for (int i = 0; i < 5; i++) begin
            tick1();
            check("reset pwm_data", pwm_data, 0);
            check("reset period_start", period_start, 0);
        end
        @(negedge clk);
        arst = 1'b0;
        wait_ps("first boundary", k);
        check("cycles to first period_start", k, 255);
        measure();
        for (int c = 0; c < CH; c++) check($sformatf("initial kick ch%0d", c), hcnt[c], 255);
        advance(50);
        @(negedge clk);
        speed = '0;
        wait_ps("stop", k);
        measure();
        check("stopped ch0 high", hcnt[0], 0);
        check("stopped at_target", at_target, 4'hF);

        // 2. kick from stop on ch0
        advance(100);
        set_speed(0, 100);
        wait_ps("t2 boundary", k);
        check("t2 no change before boundary", hcnt[0], 0);
        measure(); sum = hcnt[0];
        measure(); sum += hcnt[0];
        check("t2 kick high cycles", sum, 510);
        measure();
        check("t2 run high", hcnt[0], 100);
        check("t2 at_target0", at_target[0], 1);

        // 3. ramp up ch1 100 -> 120
        advance(60);
        set_speed(1, 100);
        wait_ps("t3 kick", k);
        measure(); measure(); measure();
        check("t3 start duty", hcnt[1], 100);
        advance(30);
        set_speed(1, 120);
        wait_ps("t3 ramp", k);
        for (int i = 0; i < 5; i++) begin
            measure();
            check($sformatf("t3 ramp period %0d", i), hcnt[1], 104 + 4 * i);
            check($sformatf("t3 at_target1 period %0d", i), at_target[1], (i == 4) ? 1 : 0);
        end

        // 4. ramp to stop on ch2
        advance(20);
        set_speed(2, 8);
        wait_ps("t4 kick", k);
        measure(); measure(); measure();
        check("t4 start duty", hcnt[2], 8);
        advance(20);
        set_speed(2, 0);
        wait_ps("t4 ramp", k);
        measure(); check("t4 duty 4", hcnt[2], 4);
        measure(); check("t4 duty 0", hcnt[2], 0);
        measure(); check("t4 off low", hcnt[2], 0);
        check("t4 at_target2", at_target[2], 1);
        advance(10);
        set_speed(2, 50);
        wait_ps("t4 rekick", k);
        measure(); check("t4 rekick high", hcnt[2], 255);

        // 5. extremes on ch3
        advance(20);
        set_speed(3, 255);
        wait_ps("t5 kick", k);
        measure(); measure();
        measure(); sum = hcnt[3];
        measure(); sum += hcnt[3];
        check("t5 full across wrap", sum, 510);
        advance(20);
        set_speed(3, 1);
        wait_ps("t5 down", k);
        for (int i = 0; i < 65; i++) begin
            measure();
            if (i == 0)  check("t5 first step", hcnt[3], 251);
            if (i == 62) check("t5 step to 3", hcnt[3], 3);
            if (i == 63) check("t5 reach 1", hcnt[3], 1);
            if (i == 64) check("t5 hold 1", hcnt[3], 1);
        end

        // 6. aborts: enable drop mid-KICK, then arst mid-RUN
        @(negedge clk);
        speed = {8'd0, 8'd0, 8'd0, 8'd60};
        enable = 1'b0;
        tick1();
        check("t6 disable pwm", pwm_data, 0);
        advance(3);
        @(negedge clk);
        enable = 1'b1;
        wait_ps("t6 first kick", k);
        check("t6 cycles to boundary", k, 255);
        advance(100);
        check("t6 mid kick ch0", pwm_data[0], 1);
        @(negedge clk);
        enable = 1'b0;
        tick1();
        check("t6 abort pwm", pwm_data, 0);
        check("t6 abort period_start", period_start, 0);
        nps = 0;
        for (int i = 0; i < 300; i++) begin
            tick1();
            if (period_start) nps++;
        end
        check("t6 no period_start while disabled", nps, 0);
        @(negedge clk);
        enable = 1'b1;
        wait_ps("t6 reenable", k);
        check("t6 reenable cycles", k, 255);
        measure(); check("t6 kick restart", hcnt[0], 255);
        measure(); measure();
        check("t6 run duty", hcnt[0], 60);
        advance(30);
        @(negedge clk);
        arst = 1'b1;
        tick1();
        check("t6 arst pwm", pwm_data, 0);
        check("t6 arst period_start", period_start, 0);
        @(negedge clk);
        arst = 1'b0;
        wait_ps("t6 after arst", k);
        check("t6 arst cycles", k, 255);
        measure(); check("t6 arst kick", hcnt[0], 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
